// File: rtl/cache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// cache_refill_ctrl
//   Miss handler and write-side driver for a direct-mapped synchronous cache.
//   Takes one CPU read at a time, presents the address to the cache read port,
//   waits out the fixed hit latency and either returns the cached word or
//   fetches it from main memory (req/ack), writes it into the cache and then
//   returns it. A memory fetch that is not acknowledged within TIMEOUT cycles
//   is aborted and reported with err_o.
//
// Parameters
//   DATAW    data / address width
//   HIT_LAT  clock edges from rdaddr_o change to valid hit_i / cache_data_i
//   TIMEOUT  maximum number of MEMREQ cycles before abort (8-bit counter)
//   CNTW     width of the saturating hit / miss statistics counters
//
// Ports
//   clk_i, rst_ni   clock (rising edge), asynchronous active-low reset
//   req_i, addr_i   CPU read request and byte address, sampled only in IDLE
//   busy_o          high in every state except IDLE
//   ready_o         1-cycle pulse: data_o valid, transaction done
//   data_o          returned word, held until the next ready_o
//   err_o           1-cycle pulse together with ready_o on memory timeout
//   rdaddr_o        cache read address (latched CPU address)
//   hit_i           cache hit flag
//   cache_data_i    cache read data
//   we_o            cache write enable (FILL only)
//   addw_o          cache write address (word aligned tag + index)
//   dataw_o         cache write data
//   mem_req_o       memory read request, level
//   mem_addr_o      memory word address
//   mem_ack_i       memory data valid, sampled only in MEMREQ
//   mem_data_i      memory read data
//   hit_cnt_o       saturating hit count
//   miss_cnt_o      saturating miss count (timeouts included)
// -----------------------------------------------------------------------------
module cache_refill_ctrl #(
    parameter int unsigned DATAW   = 32,
    parameter int unsigned HIT_LAT = 3,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNTW    = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_i,
    input  logic [DATAW-1:0] addr_i,
    output logic             busy_o,
    output logic             ready_o,
    output logic [DATAW-1:0] data_o,
    output logic             err_o,
    output logic [DATAW-1:0] rdaddr_o,
    input  logic             hit_i,
    input  logic [DATAW-1:0] cache_data_i,
    output logic             we_o,
    output logic [DATAW-1:0] addw_o,
    output logic [DATAW-1:0] dataw_o,
    output logic             mem_req_o,
    output logic [DATAW-1:0] mem_addr_o,
    input  logic             mem_ack_i,
    input  logic [DATAW-1:0] mem_data_i,
    output logic [CNTW-1:0]  hit_cnt_o,
    output logic [CNTW-1:0]  miss_cnt_o
);

    localparam int unsigned LATW = (HIT_LAT > 0) ? $clog2(HIT_LAT + 1) : 1;
    localparam int unsigned TOW  = 8;

    localparam logic [LATW-1:0] LAT_LAST = LATW'(HIT_LAT);
    localparam logic [TOW-1:0]  TO_LAST  = TOW'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_MEMREQ = 3'd2;
    localparam logic [2:0] S_FILL   = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    // state and datapath registers
    logic [2:0]       r_state;
    logic [LATW-1:0]  r_lat;
    logic [TOW-1:0]   r_to;
    logic [DATAW-1:0] r_addr;
    logic [DATAW-1:0] r_mem_data;
    logic [DATAW-1:0] r_data;
    logic             r_abort;

    // registered control outputs
    logic             r_busy;
    logic             r_ready;
    logic             r_err;
    logic             r_we;
    logic             r_mem_req;
    logic [CNTW-1:0]  r_hit_cnt;
    logic [CNTW-1:0]  r_miss_cnt;

    // next-state values
    logic [2:0]       w_state_nxt;
    logic [LATW-1:0]  w_lat_nxt;
    logic [TOW-1:0]   w_to_nxt;
    logic [DATAW-1:0] w_addr_nxt;
    logic [DATAW-1:0] w_mem_data_nxt;
    logic [DATAW-1:0] w_data_nxt;
    logic             w_abort_nxt;
    logic             w_hit_inc;
    logic             w_miss_inc;
    logic [DATAW-1:0] w_word_addr;

    // memory and cache writes always use the word-aligned address
    assign w_word_addr = {r_addr[DATAW-1:2], 2'b00};

    // next-state and datapath decode
    always_comb begin
        w_state_nxt    = r_state;
        w_lat_nxt      = r_lat;
        w_to_nxt       = r_to;
        w_addr_nxt     = r_addr;
        w_mem_data_nxt = r_mem_data;
        w_data_nxt     = r_data;
        w_abort_nxt    = r_abort;
        w_hit_inc      = 1'b0;
        w_miss_inc     = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_abort_nxt = 1'b0;
                if (req_i) begin
                    w_addr_nxt  = addr_i;
                    w_lat_nxt   = '0;
                    w_state_nxt = S_LOOKUP;
                end
            end

            // hit_i / cache_data_i are only trusted in the last latency cycle
            S_LOOKUP: begin
                if (r_lat == LAT_LAST) begin
                    if (hit_i) begin
                        w_data_nxt  = cache_data_i;
                        w_hit_inc   = 1'b1;
                        w_state_nxt = S_RESP;
                    end else begin
                        w_miss_inc  = 1'b1;
                        w_to_nxt    = '0;
                        w_state_nxt = S_MEMREQ;
                    end
                end else begin
                    w_lat_nxt = r_lat + LATW'(1);
                end
            end

            // an ack in the timeout cycle still wins over the abort
            S_MEMREQ: begin
                if (mem_ack_i) begin
                    w_mem_data_nxt = mem_data_i;
                    w_state_nxt    = S_FILL;
                end else if (r_to == TO_LAST) begin
                    w_data_nxt  = '0;
                    w_abort_nxt = 1'b1;
                    w_state_nxt = S_RESP;
                end else begin
                    w_to_nxt = r_to + TOW'(1);
                end
            end

            S_FILL: begin
                w_data_nxt  = r_mem_data;
                w_state_nxt = S_RESP;
            end

            S_RESP: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // state register; control outputs are registered from the next state so
    // they line up exactly with the state they belong to
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_lat      <= '0;
            r_to       <= '0;
            r_addr     <= '0;
            r_mem_data <= '0;
            r_data     <= '0;
            r_abort    <= 1'b0;
            r_busy     <= 1'b0;
            r_ready    <= 1'b0;
            r_err      <= 1'b0;
            r_we       <= 1'b0;
            r_mem_req  <= 1'b0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lat      <= w_lat_nxt;
            r_to       <= w_to_nxt;
            r_addr     <= w_addr_nxt;
            r_mem_data <= w_mem_data_nxt;
            r_data     <= w_data_nxt;
            r_abort    <= w_abort_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_ready    <= (w_state_nxt == S_RESP);
            r_err      <= (w_state_nxt == S_RESP) && w_abort_nxt;
            r_we       <= (w_state_nxt == S_FILL);
            r_mem_req  <= (w_state_nxt == S_MEMREQ);
            if (w_hit_inc && (r_hit_cnt != {CNTW{1'b1}})) begin
                r_hit_cnt <= r_hit_cnt + CNTW'(1);
            end
            if (w_miss_inc && (r_miss_cnt != {CNTW{1'b1}})) begin
                r_miss_cnt <= r_miss_cnt + CNTW'(1);
            end
        end
    end

    assign busy_o     = r_busy;
    assign ready_o    = r_ready;
    assign err_o      = r_err;
    assign data_o     = r_data;
    assign rdaddr_o   = r_addr;
    assign we_o       = r_we;
    assign addw_o     = w_word_addr;
    assign dataw_o    = r_mem_data;
    assign mem_req_o  = r_mem_req;
    assign mem_addr_o = w_word_addr;
    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_refill_ctrl
//   Self-checking bench for cache_refill_ctrl. A second instance with 4-bit
//   counters shares all stimulus so counter saturation is reachable quickly.
// -----------------------------------------------------------------------------
module tb_cache_refill_ctrl;

    localparam int unsigned DATAW = 32;
    localparam int unsigned CNTW  = 16;
    localparam int unsigned SCNTW = 4;

    logic              clk_i;
    logic              rst_ni;
    logic              req_i;
    logic [DATAW-1:0]  addr_i;
    logic              hit_i;
    logic [DATAW-1:0]  cache_data_i;
    logic              mem_ack_i;
    logic [DATAW-1:0]  mem_data_i;

    logic              busy_o, ready_o, err_o, we_o, mem_req_o;
    logic [DATAW-1:0]  data_o, rdaddr_o, addw_o, dataw_o, mem_addr_o;
    logic [CNTW-1:0]   hit_cnt_o, miss_cnt_o;

    logic              s_busy_o, s_ready_o, s_err_o, s_we_o, s_mem_req_o;
    logic [DATAW-1:0]  s_data_o, s_rdaddr_o, s_addw_o, s_dataw_o, s_mem_addr_o;
    logic [SCNTW-1:0]  s_hit_cnt_o, s_miss_cnt_o;

    cache_refill_ctrl #(.DATAW(DATAW), .HIT_LAT(3), .TIMEOUT(255), .CNTW(CNTW)) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .addr_i(addr_i),
        .busy_o(busy_o), .ready_o(ready_o), .data_o(data_o), .err_o(err_o),
        .rdaddr_o(rdaddr_o), .hit_i(hit_i), .cache_data_i(cache_data_i),
        .we_o(we_o), .addw_o(addw_o), .dataw_o(dataw_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    cache_refill_ctrl #(.DATAW(DATAW), .HIT_LAT(3), .TIMEOUT(255), .CNTW(SCNTW)) u_sat (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .addr_i(addr_i),
        .busy_o(s_busy_o), .ready_o(s_ready_o), .data_o(s_data_o), .err_o(s_err_o),
        .rdaddr_o(s_rdaddr_o), .hit_i(hit_i), .cache_data_i(cache_data_i),
        .we_o(s_we_o), .addw_o(s_addw_o), .dataw_o(s_dataw_o),
        .mem_req_o(s_mem_req_o), .mem_addr_o(s_mem_addr_o),
        .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
        .hit_cnt_o(s_hit_cnt_o), .miss_cnt_o(s_miss_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // field order: addr, hit, cdata, delay, mdata, busy_addr,
    //              exp_data, exp_err, exp_memcyc, exp_we, exp_rdy
    typedef struct {
        logic [31:0] addr;
        logic        hit;
        logic [31:0] cdata;
        int unsigned delay;
        logic [31:0] mdata;
        logic [31:0] busy_addr;
        logic [31:0] exp_data;
        logic        exp_err;
        int unsigned exp_memcyc;
        int unsigned exp_we;
        int unsigned exp_rdy;
    } vec_t;

    typedef struct {
        logic [31:0]      data;
        logic             err;
        logic [CNTW-1:0]  hit_cnt;
        logic [CNTW-1:0]  miss_cnt;
        logic [SCNTW-1:0] s_hit;
        logic [SCNTW-1:0] s_miss;
    } exp_t;

    exp_t             exp_q[$];
    exp_t             mon_e;
    int               n_checks = 0;
    int               n_fail   = 0;
    logic [CNTW-1:0]  m_hit, m_miss;
    logic [SCNTW-1:0] ms_hit, ms_miss;
    logic [31:0]      last_data;
    vec_t             vecs[9];
    vec_t             vt;
    logic             rh;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hit = '0; m_miss = '0; ms_hit = '0; ms_miss = '0;
        last_data = '0;
        exp_q.delete();
    endtask

    task automatic push_exp(input logic hit, input logic err, input logic [31:0] data);
        exp_t e;
        if (hit) begin
            if (m_hit != {CNTW{1'b1}})    m_hit  = m_hit + CNTW'(1);
            if (ms_hit != {SCNTW{1'b1}})  ms_hit = ms_hit + SCNTW'(1);
        end else begin
            if (m_miss != {CNTW{1'b1}})   m_miss  = m_miss + CNTW'(1);
            if (ms_miss != {SCNTW{1'b1}}) ms_miss = ms_miss + SCNTW'(1);
        end
        e.data = data; e.err = err;
        e.hit_cnt = m_hit; e.miss_cnt = m_miss; e.s_hit = ms_hit; e.s_miss = ms_miss;
        exp_q.push_back(e);
    endtask

    function automatic vec_t mk_vec(input logic [31:0] addr, input logic hit, input logic [31:0] cdata,
                                    input int unsigned delay, input logic [31:0] mdata, input logic [31:0] busy_addr);
        vec_t v;
        v.addr = addr; v.hit = hit; v.cdata = cdata; v.delay = delay; v.mdata = mdata; v.busy_addr = busy_addr;
        v.exp_err    = !hit && (delay >= 255);
        v.exp_data   = hit ? cdata : (v.exp_err ? 32'h0 : mdata);
        v.exp_memcyc = hit ? 0 : ((delay >= 255) ? 255 : delay + 1);
        v.exp_we     = (!hit && !v.exp_err) ? 1 : 0;
        v.exp_rdy    = hit ? 0 : (v.exp_err ? 255 : v.exp_memcyc + 1);
        return v;
    endfunction

    // one complete CPU read, starting with the IDLE cycle
    task automatic do_txn(input vec_t v);
        int unsigned k, we_cnt, s_we_cnt, rdy_c;
        bit          done;
        logic [31:0] waddr;
        waddr = {v.addr[31:2], 2'b00};
        @(negedge clk_i);
        chk("idle_busy", 32'(busy_o), 32'd0);
        chk("idle_busy_sat", 32'(s_busy_o), 32'd0);
        chk("hold_data", data_o, last_data);
        req_i = 1'b1; addr_i = v.addr;
        hit_i = ~v.hit; cache_data_i = $urandom;
        mem_ack_i = 1'b1; mem_data_i = $urandom;
        push_exp(v.hit, v.exp_err, v.exp_data);
        last_data = v.exp_data;
        @(negedge clk_i);
        req_i = 1'b0; addr_i = $urandom;
        for (int j = 1; j <= 4; j++) begin
            chk("lookup_busy", 32'(busy_o), 32'd1);
            chk("lookup_rdaddr", rdaddr_o, v.addr);
            chk("lookup_rdaddr_sat", s_rdaddr_o, v.addr);
            chk("lookup_we", 32'(we_o), 32'd0);
            chk("lookup_memreq", 32'(mem_req_o), 32'd0);
            hit_i        = (j == 4) ? v.hit : ~v.hit;
            cache_data_i = (j == 4) ? v.cdata : $urandom;
            mem_ack_i    = 1'b1;
            mem_data_i   = $urandom;
            @(negedge clk_i);
        end
        hit_i = 1'b0; mem_ack_i = 1'b0;
        k = 0; we_cnt = 0; s_we_cnt = 0; rdy_c = 0; done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            if (we_o) begin
                we_cnt++;
                chk("fill_addw", addw_o, waddr);
                chk("fill_dataw", dataw_o, v.mdata);
                chk("fill_memreq", 32'(mem_req_o), 32'd0);
            end
            if (s_we_o) begin
                s_we_cnt++;
                chk("fill_addw_sat", s_addw_o, waddr);
                chk("fill_dataw_sat", s_dataw_o, v.mdata);
            end
            if (mem_req_o) begin
                k++;
                chk("mem_addr", mem_addr_o, waddr);
            end
            if (s_mem_req_o) chk("mem_addr_sat", s_mem_addr_o, waddr);
            if (ready_o) begin
                done = 1'b1;
                rdy_c = c;
                chk("ready_sat", 32'(s_ready_o), 32'd1);
            end else begin
                mem_ack_i  = (mem_req_o && (k == v.delay + 1)) ? 1'b1 : 1'b0;
                mem_data_i = mem_ack_i ? v.mdata : $urandom;
                if (v.busy_addr != 32'h0 && mem_req_o && k == 2) begin
                    req_i = 1'b1; addr_i = v.busy_addr;
                end else begin
                    req_i = 1'b0;
                end
                @(negedge clk_i);
            end
        end
        mem_ack_i = 1'b0; req_i = 1'b0;
        chk("ready_seen", 32'(done), 32'd1);
        chk("ready_latency", rdy_c, v.exp_rdy);
        chk("memreq_cycles", k, v.exp_memcyc);
        chk("we_pulses", we_cnt, v.exp_we);
        chk("we_pulses_sat", s_we_cnt, v.exp_we);
        // a request during RESP must be dropped
        req_i = 1'b1; addr_i = ~v.addr;
    endtask

    // scoreboard: compare on every ready_o pulse
    always @(negedge clk_i) begin
        if (rst_ni && ready_o) begin
            if (exp_q.size() == 0) begin
                chk("spurious_ready", 32'(ready_o), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("resp_data", data_o, mon_e.data);
                chk("resp_err", 32'(err_o), 32'(mon_e.err));
                chk("hit_cnt", 32'(hit_cnt_o), 32'(mon_e.hit_cnt));
                chk("miss_cnt", 32'(miss_cnt_o), 32'(mon_e.miss_cnt));
                chk("resp_data_sat", s_data_o, mon_e.data);
                chk("resp_err_sat", 32'(s_err_o), 32'(mon_e.err));
                chk("hit_cnt_sat", 32'(s_hit_cnt_o), 32'(mon_e.s_hit));
                chk("miss_cnt_sat", 32'(s_miss_cnt_o), 32'(mon_e.s_miss));
            end
        end
        if (rst_ni && err_o && !ready_o) chk("err_without_ready", 32'(err_o), 32'd0);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'h0000_0040, 1'b1, 32'hDEAD_BEEF, 0,   32'h0,         32'h0,         32'hDEAD_BEEF, 1'b0, 0,   0, 0};
        vecs[1] = '{32'h1234_5008, 1'b0, 32'h5555_AAAA, 5,   32'hCAFE_F00D, 32'h0,         32'hCAFE_F00D, 1'b0, 6,   1, 7};
        vecs[2] = '{32'h0000_1003, 1'b0, 32'h0,         0,   32'h1111_2222, 32'h0,         32'h1111_2222, 1'b0, 1,   1, 2};
        vecs[3] = '{32'h0BAD_0004, 1'b0, 32'h0,         3,   32'h3333_4444, 32'hAAAA_0000, 32'h3333_4444, 1'b0, 4,   1, 5};
        vecs[4] = '{32'hFFFF_FFFF, 1'b1, 32'h0,         0,   32'h0,         32'h0,         32'h0,         1'b0, 0,   0, 0};
        vecs[5] = '{32'h0000_2000, 1'b0, 32'h0,         254, 32'h7777_8888, 32'h0,         32'h7777_8888, 1'b0, 255, 1, 256};
        vecs[6] = '{32'h0000_3000, 1'b0, 32'h0,         255, 32'h9999_AAAA, 32'h0,         32'h0,         1'b1, 255, 0, 255};
        vecs[7] = '{32'h0000_0044, 1'b1, 32'h0123_4567, 0,   32'h0,         32'h0,         32'h0123_4567, 1'b0, 0,   0, 0};
        vecs[8] = '{32'h8000_000C, 1'b0, 32'h0,         1,   32'hFEED_FACE, 32'h0,         32'hFEED_FACE, 1'b0, 2,   1, 3};

        rst_ni = 1'b0; req_i = 1'b0; addr_i = '0; hit_i = 1'b0;
        cache_data_i = '0; mem_ack_i = 1'b0; mem_data_i = '0;
        model_reset();
        repeat (3) @(negedge clk_i);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_ready", 32'(ready_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_we", 32'(we_o), 32'd0);
        chk("rst_memreq", 32'(mem_req_o), 32'd0);
        chk("rst_data", data_o, 32'h0);
        chk("rst_rdaddr", rdaddr_o, 32'h0);
        chk("rst_hit_cnt", 32'(hit_cnt_o), 32'd0);
        chk("rst_miss_cnt", 32'(miss_cnt_o), 32'd0);
        rst_ni = 1'b1;

        // reset asserted in the middle of a memory request
        @(negedge clk_i);
        req_i = 1'b1; addr_i = 32'h0000_5000; hit_i = 1'b0; mem_ack_i = 1'b0;
        @(negedge clk_i);
        req_i = 1'b0;
        for (int c = 0; c < 20 && !mem_req_o; c++) @(negedge clk_i);
        chk("rst_pre_memreq", 32'(mem_req_o), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        chk("rst_memreq_drop", 32'(mem_req_o), 32'd0);
        chk("rst_memreq_busy", 32'(busy_o), 32'd0);
        chk("rst_memreq_we", 32'(we_o), 32'd0);
        chk("rst_memreq_drop_sat", 32'(s_mem_req_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();
        repeat (2) @(negedge clk_i);
        chk("post_rst_busy", 32'(busy_o), 32'd0);
        chk("post_rst_miss_cnt", 32'(miss_cnt_o), 32'(m_miss));

        // reset asserted while the cache write is in progress
        @(negedge clk_i);
        req_i = 1'b1; addr_i = 32'h0000_6000; hit_i = 1'b0; mem_ack_i = 1'b0;
        @(negedge clk_i);
        req_i = 1'b0;
        for (int c = 0; c < 20 && !mem_req_o; c++) @(negedge clk_i);
        mem_ack_i = 1'b1; mem_data_i = 32'h5A5A_5A5A;
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        chk("rst_pre_fill_we", 32'(we_o), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        chk("rst_fill_we", 32'(we_o), 32'd0);
        chk("rst_fill_dataw", dataw_o, 32'h0);
        chk("rst_fill_busy", 32'(busy_o), 32'd0);
        chk("rst_fill_we_sat", 32'(s_we_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();

        // directed table, back-to-back with no idle gap
        for (int i = 0; i < 9; i++) do_txn(vecs[i]);

        // mixed traffic; drives both counters of the narrow instance past saturation
        for (int i = 0; i < 36; i++) begin
            rh = ((i % 3) != 0);
            vt = mk_vec({$urandom_range(0, 32'h3FFF_FFFF), 2'b00} | 32'(i & 3), rh, $urandom,
                        $urandom_range(1, 6), $urandom, ((i % 6) == 3) ? 32'hC0DE_0000 : 32'h0);
            do_txn(vt);
        end

        @(negedge clk_i);
        req_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("final_busy", 32'(busy_o), 32'd0);
        chk("final_hit_sat", 32'(s_hit_cnt_o), 32'(ms_hit));
        chk("scoreboard_drain", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
